// File: rtl/rvfi_bus_dmem_tracker.sv
// Purpose : producer side of the RVFI bus-observation interface for one data-memory port.
//           It tracks in-order dmem requests in a small FIFO and emits one rvfi_bus_* record
//           for each completed transaction.
// Latency : the record appears exactly 1 cycle after the rsp_valid that completes it.
// Backpr. : req_ready drops when DEPTH requests are outstanding. Responses cannot be stalled.
//
// Ports:
//   clock, reset                      rising-edge clock; asynchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_addr/rmask/wmask/wdata        request payload
//   rsp_valid, rsp_rdata, rsp_fault   response for the oldest outstanding request
//   rvfi_bus_*                        registered record; valid pulses, other fields hold
//   outstanding                       current FIFO occupancy
//   protocol_error                    sticky flag, set by a response with nothing outstanding
module rvfi_bus_dmem_tracker #(
  parameter int XLEN   = 32,
  parameter int BUSLEN = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XLEN-1:0]          req_addr,
  input  logic [BUSLEN/8-1:0]      req_rmask,
  input  logic [BUSLEN/8-1:0]      req_wmask,
  input  logic [BUSLEN-1:0]        req_wdata,
  input  logic                     rsp_valid,
  input  logic [BUSLEN-1:0]        rsp_rdata,
  input  logic                     rsp_fault,
  output logic                     rvfi_bus_valid,
  output logic                     rvfi_bus_insn,
  output logic                     rvfi_bus_data,
  output logic                     rvfi_bus_fault,
  output logic [XLEN-1:0]          rvfi_bus_addr,
  output logic [BUSLEN/8-1:0]      rvfi_bus_rmask,
  output logic [BUSLEN-1:0]        rvfi_bus_rdata,
  output logic [BUSLEN/8-1:0]      rvfi_bus_wmask,
  output logic [BUSLEN-1:0]        rvfi_bus_wdata,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     protocol_error
);

  localparam int NB = BUSLEN / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Expand a byte-enable mask into a bit mask.
  function automatic logic [BUSLEN-1:0] byte_mask(input logic [NB-1:0] m);
    logic [BUSLEN-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      r[i*8 +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

  // Entry storage. It has no reset because the pointers and count define which entries are valid.
  logic [XLEN-1:0]   addr_mem  [DEPTH];
  logic [NB-1:0]     rmask_mem [DEPTH];
  logic [NB-1:0]     wmask_mem [DEPTH];
  logic [BUSLEN-1:0] wdata_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic accept;
  logic complete;
  logic orphan_rsp;

  // req_ready depends only on the registered count, so it has no path from rsp_valid.
  assign req_ready  = (count != CW'(DEPTH));
  assign accept     = req_valid && req_ready;
  assign complete   = rsp_valid && (count != '0);
  assign orphan_rsp = rsp_valid && (count == '0);

  assign outstanding   = count;
  assign rvfi_bus_insn = 1'b0;
  assign rvfi_bus_data = 1'b1;

  always_ff @(posedge clock) begin
    if (accept) begin
      addr_mem[wr_ptr]  <= req_addr;
      rmask_mem[wr_ptr] <= req_rmask;
      wmask_mem[wr_ptr] <= req_wmask;
      wdata_mem[wr_ptr] <= req_wdata;
    end
  end

  // Pointers wrap modulo DEPTH because DEPTH is a power of two.
  // A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (complete) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (accept && !complete) begin
        count <= count + CW'(1);
      end else if (!accept && complete) begin
        count <= count - CW'(1);
      end
      if (orphan_rsp) begin
        protocol_error <= 1'b1;
      end
    end
  end

  // Record register. Only valid pulses; the payload fields keep their last record.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvfi_bus_valid <= 1'b0;
      rvfi_bus_fault <= 1'b0;
      rvfi_bus_addr  <= '0;
      rvfi_bus_rmask <= '0;
      rvfi_bus_rdata <= '0;
      rvfi_bus_wmask <= '0;
      rvfi_bus_wdata <= '0;
    end else begin
      rvfi_bus_valid <= complete;
      if (complete) begin
        rvfi_bus_fault <= rsp_fault;
        rvfi_bus_addr  <= addr_mem[rd_ptr];
        rvfi_bus_rmask <= rmask_mem[rd_ptr];
        rvfi_bus_wmask <= wmask_mem[rd_ptr];
        rvfi_bus_wdata <= wdata_mem[rd_ptr] & byte_mask(wmask_mem[rd_ptr]);
        // A faulted response carries no usable read data.
        rvfi_bus_rdata <= rsp_fault ? '0 : (rsp_rdata & byte_mask(rmask_mem[rd_ptr]));
      end
    end
  end

endmodule
